// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time round sequencer.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WAIT  = 3'd2,
    SHOW  = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_e;

  localparam int unsigned LED_IDX_T0 = 1;
  localparam int unsigned LED_IDX_T1 = 5;
  localparam int unsigned LED_IDX_T2 = 3;
  localparam int unsigned LED_IDX_T3 = 7;

  localparam logic [7:0]  LED_FAULT  = 8'h01;
  localparam logic [4:0]  LFSR_SEED  = 5'd5;
  localparam logic [15:0] BCD_SAT    = 16'h9999;

  function automatic logic [7:0] target_led(input logic [1:0] t);
    logic [7:0] v;
    v = '0;
    case (t)
      2'd0:    v[LED_IDX_T0] = 1'b1;
      2'd1:    v[LED_IDX_T1] = 1'b1;
      2'd2:    v[LED_IDX_T2] = 1'b1;
      default: v[LED_IDX_T3] = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter: synchronous clear, increment enable, sticks at 9999.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt,
  output logic        carry_out
);

  logic [15:0] cnt_q, cnt_d;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Flags that the next increment would overflow, so the caller can act on it in the same cycle.
  assign carry_out = (cnt_q == BCD_SAT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !carry_out) begin
      cnt_d = bcd_inc(cnt_q);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// One round of the reaction-time game: random wait, target LED, BCD reaction timer.
// Define REACT_FALSE_START_EN to turn a press during WAIT into a FAULT.
//   state | meaning
//   IDLE  | game disabled, LEDs dark
//   ARM   | clear result, wait for all keys released
//   WAIT  | random delay, counted in ticks
//   SHOW  | target lit, timing the reaction
//   DONE  | result held until any press
//   FAULT | false start shown
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned MIN_DELAY = 100,
  parameter int unsigned RAND_STEP = 8
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        SW_RUN,
  input  logic [3:0]  KEY,
  output logic [7:0]  LEDR,
  output logic [15:0] time_bcd,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        fault
);

  localparam int unsigned DLY_MAX = MIN_DELAY + 31 * RAND_STEP;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;

  state_e        state_q, state_d;
  logic          sw_s1_q, sw_s2_q;
  logic [3:0]    key_s1_q, key_s2_q, key_prev_q;
  logic [4:0]    lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [1:0]    target_q, target_d;
  logic          sat_q, sat_d;
  logic [7:0]    led_q, led_d;
  logic          busy_q, busy_d, done_q, done_d, timeout_q, timeout_d, fault_q, fault_d;
  logic [3:0]    press;
  logic          tick, cnt_clr, cnt_inc, cnt_carry, entering;

  assign press = key_prev_q & ~key_s2_q;
  assign tick  = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    target_d = target_q;
    sat_d    = sat_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    if (!sw_s2_q) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          cnt_clr = 1'b1;
          sat_d   = 1'b0;
          if (&key_s2_q) begin
            state_d = WAIT;
            delay_d = DW'(MIN_DELAY) + DW'(RAND_STEP) * DW'(lfsr_q);
          end
        end
        WAIT: begin
`ifdef REACT_FALSE_START_EN
          if (|press) begin
            state_d = FAULT;
          end else
`endif
          if (delay_q == '0) begin
            state_d  = SHOW;
            target_d = lfsr_q[1:0];
          end else if (tick) begin
            delay_d = delay_q - DW'(1);
          end
        end
        SHOW: begin
          // A correct press beats a coincident tick, so the count is not bumped.
          if (press[target_q]) begin
            state_d = DONE;
          end else if (tick) begin
            cnt_inc = 1'b1;
            if (cnt_carry) begin
              state_d = DONE;
              sat_d   = 1'b1;
            end
          end
        end
        DONE: if (|press) state_d = ARM;
`ifdef REACT_FALSE_START_EN
        FAULT: begin
          cnt_clr = 1'b1;
          if (|press) state_d = ARM;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_d   = {lfsr_q[3:0], ~(lfsr_q[4] ^ lfsr_q[2])};
    entering = (state_d != state_q) && ((state_d == WAIT) || (state_d == SHOW));
    presc_d  = (entering || tick) ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    led_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    fault_d   = 1'b0;
    case (state_q)
      ARM, WAIT: busy_d = 1'b1;
      SHOW: begin
        busy_d = 1'b1;
        led_d  = target_led(target_q);
      end
      DONE: begin
        done_d    = 1'b1;
        timeout_d = sat_q;
        led_d     = target_led(target_q);
      end
`ifdef REACT_FALSE_START_EN
      FAULT: begin
        fault_d = 1'b1;
        led_d   = LED_FAULT;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      sw_s1_q    <= 1'b0;
      sw_s2_q    <= 1'b0;
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      key_prev_q <= '0;
      lfsr_q     <= LFSR_SEED;
      presc_q    <= '0;
      delay_q    <= '0;
      target_q   <= '0;
      sat_q      <= 1'b0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_s1_q    <= SW_RUN;
      sw_s2_q    <= sw_s1_q;
      key_s1_q   <= KEY;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      lfsr_q     <= lfsr_d;
      presc_q    <= presc_d;
      delay_q    <= delay_d;
      target_q   <= target_d;
      sat_q      <= sat_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      fault_q    <= fault_d;
    end
  end

  bcd_counter4 u_time (
    .clk_sys   (CLOCK_50),
    .rst_b     (RESET_N),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .cnt       (time_bcd),
    .carry_out (cnt_carry)
  );

  assign LEDR    = led_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign fault   = fault_q;

endmodule
